// File: rtl/ofdm_ifft_sequencer_if.sv
// ofdm_ifft_sequencer_if
//   AXI4-Stream style bundle used for every streaming port of the IFFT
//   sequencer (mapper input, core config, core in/out, DAC-side output).
//   Parameters: W - tdata width.
//   Signals:    tdata[W-1:0], tvalid, tlast (source -> sink), tready (sink -> source).
//   Modports:   master - drives tdata/tvalid/tlast, samples tready.
//               slave  - samples tdata/tvalid/tlast, drives tready.
interface ofdm_ifft_sequencer_if #(
  parameter int unsigned W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ofdm_ifft_sequencer.sv
// ofdm_ifft_sequencer
//   Sequences the IFFT core in the OFDM transmit chain. Issues the core
//   config word after reset or on request, frames the mapper stream into
//   NFFT-sample symbols with generated tlast, captures the core output into
//   a ping-pong buffer and replays each symbol with its cyclic prefix.
//   Ports:
//     aclk, aresetn   - clock, asynchronous active-low reset
//     cfg_reload_i    - single-cycle request to re-issue the config word
//     s_axis  (slave) - mapper samples {imag[15:0], real[15:0]}
//     cfg     (master)- core config word (constant CFG_TDATA)
//     fft_in  (master)- samples to the core, tlast every NFFT samples
//     fft_out (slave) - frequency-to-time samples from the core
//     m_axis  (master)- CP-extended time samples, tlast every NFFT+CP_LEN
//     symbol_count_o  - symbols emitted on m_axis, wraps at 2^16
//     tlast_err_o     - sticky: core tlast disagreed with the write counter
module ofdm_ifft_sequencer #(
  parameter int unsigned NFFT      = 32,
  parameter int unsigned CP_LEN    = 16,
  parameter logic [23:0] CFG_TDATA = 24'h541006
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cfg_reload_i,
  ofdm_ifft_sequencer_if.slave  s_axis,
  ofdm_ifft_sequencer_if.master cfg,
  ofdm_ifft_sequencer_if.master fft_in,
  ofdm_ifft_sequencer_if.slave  fft_out,
  ofdm_ifft_sequencer_if.master m_axis,
  output logic [15:0]           symbol_count_o,
  output logic                  tlast_err_o
);

  localparam int unsigned IDX_W   = $clog2(NFFT);
  localparam int unsigned OUT_LEN = NFFT + CP_LEN;
  localparam int unsigned RD_W    = $clog2(OUT_LEN);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NFFT - 1);
  localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(OUT_LEN - 1);
  localparam logic [RD_W-1:0]  RD_CP    = RD_W'(CP_LEN);

  // ---------------------------------------------------------------------
  // Control FSM: config issue and input framing
  // ---------------------------------------------------------------------
  typedef enum logic {
    ST_CFG = 1'b0,
    ST_RUN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] in_idx_q, in_idx_d;
  logic             reload_pend_q, reload_pend_d;
  logic             run_pass_c;
  logic             cfg_valid_c;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_CFG;
      in_idx_q      <= '0;
      reload_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_idx_q      <= in_idx_d;
      reload_pend_q <= reload_pend_d;
    end
  end

  // A pending reload is only honoured at a symbol boundary; in that cycle
  // the passthrough is closed so no sample of the next symbol slips in.
  always_comb begin
    state_d       = state_q;
    in_idx_d      = in_idx_q;
    reload_pend_d = reload_pend_q;
    run_pass_c    = 1'b0;
    cfg_valid_c   = 1'b0;
    case (state_q)
      ST_CFG: begin
        cfg_valid_c = 1'b1;
        if (cfg.tready) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cfg_reload_i) begin
          reload_pend_d = 1'b1;
        end
        if (reload_pend_q && (in_idx_q == '0)) begin
          state_d       = ST_CFG;
          reload_pend_d = 1'b0;
        end else begin
          run_pass_c = 1'b1;
          if (s_axis.tvalid && fft_in.tready) begin
            in_idx_d = (in_idx_q == IDX_LAST) ? '0 : in_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_CFG;
    endcase
  end

  assign cfg.tvalid    = cfg_valid_c;
  assign cfg.tdata     = CFG_TDATA;
  assign cfg.tlast     = 1'b0;
  assign s_axis.tready = run_pass_c & fft_in.tready;
  assign fft_in.tvalid = run_pass_c & s_axis.tvalid;
  assign fft_in.tdata  = s_axis.tdata;
  assign fft_in.tlast  = (in_idx_q == IDX_LAST);

  // ---------------------------------------------------------------------
  // Ping-pong output buffer with cyclic-prefix replay
  // ---------------------------------------------------------------------
  logic [31:0]      ram_q [2][NFFT];
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             rd_bank_q, rd_bank_d;
  logic [RD_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [1:0]       full_q, full_d;
  logic [15:0]      sym_cnt_q, sym_cnt_d;
  logic             tlast_err_q, tlast_err_d;
  logic             wr_hs_c, wr_last_c, rd_hs_c, rd_last_c;
  logic [IDX_W-1:0] rd_addr_c;

  assign wr_hs_c   = fft_out.tvalid & ~full_q[wr_bank_q];
  assign wr_last_c = (wr_idx_q == IDX_LAST);
  assign rd_hs_c   = full_q[rd_bank_q] & m_axis.tready;
  assign rd_last_c = (rd_cnt_q == RD_LAST);

  // First CP_LEN reads fetch the symbol tail, the rest the whole symbol.
  assign rd_addr_c = (rd_cnt_q < RD_CP) ? IDX_W'(NFFT - CP_LEN + rd_cnt_q)
                                        : IDX_W'(rd_cnt_q - RD_CP);

  assign fft_out.tready = ~full_q[wr_bank_q];
  assign m_axis.tvalid  = full_q[rd_bank_q];
  assign m_axis.tdata   = ram_q[rd_bank_q][rd_addr_c];
  assign m_axis.tlast   = rd_last_c;
  assign symbol_count_o = sym_cnt_q;
  assign tlast_err_o    = tlast_err_q;

  // Sample storage, no reset: contents are qualified by the full flags.
  always_ff @(posedge aclk) begin
    if (wr_hs_c) begin
      ram_q[wr_bank_q][wr_idx_q] <= fft_out.tdata;
    end
  end

  // Write and read sides only ever touch different banks, so a full-set and
  // a full-clear in the same cycle never collide.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    full_d      = full_q;
    sym_cnt_d   = sym_cnt_q;
    tlast_err_d = tlast_err_q;
    if (wr_hs_c) begin
      if (fft_out.tlast != wr_last_c) begin
        tlast_err_d = 1'b1;
      end
      if (wr_last_c) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end
    if (rd_hs_c) begin
      if (rd_last_c) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_cnt_d          = '0;
        sym_cnt_d         = sym_cnt_q + 16'd1;
      end else begin
        rd_cnt_d = rd_cnt_q + RD_W'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      full_q      <= '0;
      sym_cnt_q   <= '0;
      tlast_err_q <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      full_q      <= full_d;
      sym_cnt_q   <= sym_cnt_d;
      tlast_err_q <= tlast_err_d;
    end
  end

endmodule

// File: tb/tb_ofdm_ifft_sequencer.sv
// tb_ofdm_ifft_sequencer
//   Directed-plus-random bench for ofdm_ifft_sequencer. Expected output
//   streams are built from each core symbol as "last CP_LEN samples, then
//   the whole symbol"; input framing is checked against a running count.
`timescale 1ns/1ps
module tb_ofdm_ifft_sequencer;

  localparam int unsigned NFFT     = 32;
  localparam int unsigned CP_LEN   = 16;
  localparam int unsigned SYM_OUT  = NFFT + CP_LEN;
  localparam logic [23:0] CFG_WORD = 24'h541006;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cfg_reload;
  logic [15:0] symbol_count;
  logic        tlast_err;

  always #5 aclk = ~aclk;

  ofdm_ifft_sequencer_if #(.W(32)) s_axis_if ();
  ofdm_ifft_sequencer_if #(.W(24)) cfg_if ();
  ofdm_ifft_sequencer_if #(.W(32)) fft_in_if ();
  ofdm_ifft_sequencer_if #(.W(32)) fft_out_if ();
  ofdm_ifft_sequencer_if #(.W(32)) m_axis_if ();

  ofdm_ifft_sequencer #(
    .NFFT      (NFFT),
    .CP_LEN    (CP_LEN),
    .CFG_TDATA (CFG_WORD)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .cfg_reload_i   (cfg_reload),
    .s_axis         (s_axis_if),
    .cfg            (cfg_if),
    .fft_in         (fft_in_if),
    .fft_out        (fft_out_if),
    .m_axis         (m_axis_if),
    .symbol_count_o (symbol_count),
    .tlast_err_o    (tlast_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  logic [31:0] core_q[$];
  bit          core_last_q[$];
  logic [31:0] exp_q[$];

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    s_axis_if.tvalid  = 1'b0;
    s_axis_if.tdata   = '0;
    s_axis_if.tlast   = 1'b0;
    cfg_if.tready     = 1'b0;
    fft_in_if.tready  = 1'b0;
    fft_out_if.tvalid = 1'b0;
    fft_out_if.tdata  = '0;
    fft_out_if.tlast  = 1'b0;
    m_axis_if.tready  = 1'b0;
    cfg_reload        = 1'b0;
  endtask

  // Hold reset, check every documented reset value, then release.
  task automatic do_reset();
    aresetn = 1'b0;
    idle();
    s_axis_if.tvalid = 1'b1;
    fft_in_if.tready = 1'b1;
    @(negedge aclk);
    chk_b("rst_cfg_tvalid", cfg_if.tvalid, 1'b1);
    chk_b("rst_s_tready", s_axis_if.tready, 1'b0);
    chk_b("rst_fft_in_tvalid", fft_in_if.tvalid, 1'b0);
    chk_b("rst_fft_in_tlast", fft_in_if.tlast, 1'b0);
    chk_b("rst_fft_out_tready", fft_out_if.tready, 1'b1);
    chk_b("rst_m_tvalid", m_axis_if.tvalid, 1'b0);
    chk_b("rst_m_tlast", m_axis_if.tlast, 1'b0);
    chk_w("rst_symbol_count", 32'(symbol_count), 32'd0);
    chk_b("rst_tlast_err", tlast_err, 1'b0);
    @(posedge aclk);
    #1;
    idle();
    aresetn = 1'b1;
  endtask

  task automatic cfg_handshake();
    int hs = 0;
    cfg_if.tready = 1'b1;
    for (int c = 0; c < 10 && hs == 0; c++) begin
      @(negedge aclk);
      if (cfg_if.tvalid) begin
        hs = 1;
        chk_w("cfg_tdata", 32'(cfg_if.tdata), 32'(CFG_WORD));
      end
      tick();
    end
    cfg_if.tready = 1'b0;
    chk_w("cfg_hs_seen", 32'(hs), 32'd1);
  endtask

  // Push count mapper samples; tlast expected on every NFFT-th accepted one.
  task automatic feed_inputs(input int count, input bit rnd);
    int n = 0;
    for (int c = 0; c < 20 * count + 20 && n < count; c++) begin
      s_axis_if.tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_axis_if.tdata  = $urandom;
      fft_in_if.tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge aclk);
      chk_b("fft_in_tvalid", fft_in_if.tvalid, s_axis_if.tvalid);
      chk_b("s_tready", s_axis_if.tready, fft_in_if.tready);
      if (fft_in_if.tvalid && fft_in_if.tready) begin
        chk_w("fft_in_tdata", fft_in_if.tdata, s_axis_if.tdata);
        chk_b("fft_in_tlast", fft_in_if.tlast, (n % NFFT) == NFFT - 1);
        n++;
      end
      tick();
    end
    s_axis_if.tvalid = 1'b0;
    chk_w("in_count", 32'(n), 32'(count));
  endtask

  // Reference model: a core symbol leaves as its CP_LEN tail, then itself.
  task automatic queue_symbol(input bit ramp, input int tlast_pos);
    logic [31:0] s [NFFT];
    for (int i = 0; i < NFFT; i++) s[i] = ramp ? 32'(i) : 32'($urandom);
    for (int i = 0; i < NFFT; i++) begin
      core_q.push_back(s[i]);
      core_last_q.push_back(i == tlast_pos);
    end
    for (int i = NFFT - CP_LEN; i < NFFT; i++) exp_q.push_back(s[i]);
    for (int i = 0; i < NFFT; i++) exp_q.push_back(s[i]);
  endtask

  task automatic core_drive(input bit rnd, output int stalls, output int last_hs);
    int budget = 0;
    stalls  = 0;
    last_hs = -1;
    while (core_q.size() > 0 && budget < 4000) begin
      fft_out_if.tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      fft_out_if.tdata  = core_q[0];
      fft_out_if.tlast  = core_last_q[0];
      @(negedge aclk);
      if (fft_out_if.tvalid && !fft_out_if.tready) stalls++;
      if (fft_out_if.tvalid && fft_out_if.tready) begin
        void'(core_q.pop_front());
        void'(core_last_q.pop_front());
        last_hs = cyc;
      end
      tick();
      budget++;
    end
    fft_out_if.tvalid = 1'b0;
    fft_out_if.tlast  = 1'b0;
    chk_w("core_drained", 32'(core_q.size()), 32'd0);
  endtask

  task automatic out_mon(input bit rnd, output int first_o, output int last_o);
    int          n      = 0;
    int          budget = 0;
    int          total  = exp_q.size();
    logic        held_v = 1'b0;
    logic [31:0] held_d = '0;
    first_o = -1;
    last_o  = -1;
    while (n < total && budget < 6000) begin
      m_axis_if.tready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge aclk);
      if (held_v) begin
        chk_b("m_hold_valid", m_axis_if.tvalid, 1'b1);
        chk_w("m_hold_data", m_axis_if.tdata, held_d);
      end
      held_v = m_axis_if.tvalid && !m_axis_if.tready;
      held_d = m_axis_if.tdata;
      if (m_axis_if.tvalid && m_axis_if.tready) begin
        if (first_o < 0) first_o = cyc;
        last_o = cyc;
        chk_w("m_tdata", m_axis_if.tdata, exp_q.pop_front());
        chk_b("m_tlast", m_axis_if.tlast, (n % SYM_OUT) == SYM_OUT - 1);
        n++;
      end
      tick();
      budget++;
    end
    m_axis_if.tready = 1'b0;
    chk_w("m_count", 32'(n), 32'(total));
  endtask

  int stalls, last_hs, first_o, last_o;
  int sym_exp;
  int cfg_hs;
  int n_in;

  initial begin
    // Reset release and first config handshake at cycle 3.
    do_reset();
    fft_in_if.tready = 1'b1;
    cfg_hs = 0;
    for (int c = 0; c < 8; c++) begin
      cfg_if.tready    = (c >= 3);
      s_axis_if.tvalid = (c < 4);
      @(negedge aclk);
      chk_b("cfg_tvalid", cfg_if.tvalid, cfg_hs == 0);
      chk_b("s_tready_cfg", s_axis_if.tready, cfg_hs != 0);
      chk_b("fft_in_tvalid_cfg", fft_in_if.tvalid, (cfg_hs != 0) && s_axis_if.tvalid);
      if (cfg_if.tvalid && cfg_if.tready) begin
        cfg_hs++;
        chk_w("cfg_tdata", 32'(cfg_if.tdata), 32'(CFG_WORD));
      end
      tick();
    end
    chk_w("cfg_hs_count", 32'(cfg_hs), 32'd1);
    idle();

    // Two input symbols with random valid/ready on both sides.
    feed_inputs(64, 1'b1);
    idle();

    // Ramp symbol through the buffer: latency, CP order, count.
    sym_exp = 0;
    queue_symbol(1'b1, NFFT - 1);
    fork
      core_drive(1'b0, stalls, last_hs);
      out_mon(1'b0, first_o, last_o);
    join
    sym_exp += 1;
    chk_w("out_latency", 32'(first_o), 32'(last_hs + 1));
    chk_w("symbol_count_1", 32'(symbol_count), 32'(sym_exp));
    chk_b("tlast_err_clean", tlast_err, 1'b0);

    // Three back-to-back symbols: core backpressure, gap-free output.
    for (int i = 0; i < 3; i++) queue_symbol(1'b0, NFFT - 1);
    fork
      core_drive(1'b0, stalls, last_hs);
      out_mon(1'b0, first_o, last_o);
    join
    sym_exp += 3;
    chk_w("core_stall_cycles", 32'(stalls), 32'(CP_LEN));
    chk_w("gap_free_span", 32'(last_o - first_o + 1), 32'(3 * SYM_OUT));
    chk_w("symbol_count_4", 32'(symbol_count), 32'(sym_exp));
    @(negedge aclk);
    chk_b("m_idle_after", m_axis_if.tvalid, 1'b0);
    tick();

    // Early core tlast: sticky error, framing unchanged.
    chk_b("tlast_err_pre", tlast_err, 1'b0);
    queue_symbol(1'b0, 20);
    fork
      core_drive(1'b0, stalls, last_hs);
      out_mon(1'b0, first_o, last_o);
    join
    chk_b("tlast_err_set", tlast_err, 1'b1);
    queue_symbol(1'b0, NFFT - 1);
    fork
      core_drive(1'b0, stalls, last_hs);
      out_mon(1'b0, first_o, last_o);
    join
    sym_exp += 2;
    chk_b("tlast_err_sticky", tlast_err, 1'b1);

    // Random backpressure on both core output and downstream.
    for (int i = 0; i < 4; i++) queue_symbol(1'b0, NFFT - 1);
    fork
      core_drive(1'b1, stalls, last_hs);
      out_mon(1'b1, first_o, last_o);
    join
    sym_exp += 4;
    chk_w("symbol_count_rand", 32'(symbol_count), 32'(sym_exp));

    // Reload at in_idx 10: symbol completes, then CFG; reload in CFG ignored.
    idle();
    s_axis_if.tvalid = 1'b1;
    fft_in_if.tready = 1'b1;
    n_in = 0;
    for (int c = 0; c < 60; c++) begin
      s_axis_if.tdata = $urandom;
      cfg_reload      = (c == 10) || (c == 50);
      @(negedge aclk);
      if (n_in >= NFFT) chk_b("s_tready_reload", s_axis_if.tready, 1'b0);
      if (fft_in_if.tvalid && fft_in_if.tready) begin
        chk_w("reload_tdata", fft_in_if.tdata, s_axis_if.tdata);
        chk_b("reload_tlast", fft_in_if.tlast, n_in == NFFT - 1);
        n_in++;
      end
      tick();
    end
    cfg_reload = 1'b0;
    chk_w("reload_in_count", 32'(n_in), 32'(NFFT));
    @(negedge aclk);
    chk_b("reload_cfg_tvalid", cfg_if.tvalid, 1'b1);
    chk_b("reload_fft_in_tvalid", fft_in_if.tvalid, 1'b0);
    tick();
    s_axis_if.tvalid = 1'b0;
    cfg_handshake();
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      chk_b("post_cfg_s_tready", s_axis_if.tready, 1'b1);
      chk_b("post_cfg_cfg_tvalid", cfg_if.tvalid, 1'b0);
      tick();
    end

    // Reset mid-flight: full bank and partial input symbol are discarded.
    idle();
    queue_symbol(1'b0, NFFT - 1);
    core_drive(1'b0, stalls, last_hs);
    @(negedge aclk);
    chk_b("m_valid_before_rst", m_axis_if.tvalid, 1'b1);
    tick();
    feed_inputs(5, 1'b0);
    do_reset();
    exp_q.delete();
    cfg_handshake();
    feed_inputs(NFFT, 1'b0);
    idle();
    queue_symbol(1'b0, NFFT - 1);
    fork
      core_drive(1'b0, stalls, last_hs);
      out_mon(1'b0, first_o, last_o);
    join
    chk_w("symbol_count_after_rst", 32'(symbol_count), 32'd1);
    chk_b("tlast_err_after_rst", tlast_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
